// File: rtl/ipf_lcu_feeder.sv
// rtl/ipf_lcu_feeder.sv - LCU-ordered pixel/parameter feeder for the IPF; IPF_FEEDER_STALL_CNT_EN adds stall_cnt
module ipf_lcu_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_lcu_size,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_data,
    output logic [5:0]  par_addr,
    input  logic [23:0] par_data,
    input  logic        busy,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    output logic        active,
    output logic        done
`ifdef IPF_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        STREAM,
        WAIT_LAST,
        DONE
    } state_t;

    state_t      state;
    logic        param_ph;
    logic [5:0]  rd_row;
    logic [5:0]  rd_col;
    logic        rd_done;
    logic        rd_valid;
    logic [5:0]  out_row;
    logic [5:0]  out_col;
    logic [7:0]  fifo0;
    logic [7:0]  fifo1;
    logic [1:0]  fifo_cnt;
    logic        busy_seen;

    logic [5:0]  n_m1;
    logic [2:0]  lcu_max;
    logic [1:0]  occ;
    logic        pop;
    logic        push;
    logic        last_rd;
    logic        last_px;
    logic        last_lcu;
    logic [2:0]  nx_x;
    logic [2:0]  nx_y;
    logic [5:0]  nr_row;
    logic [5:0]  nr_col;

    // Image address of pixel (r,c) inside LCU (lx,ly); LCU offsets are aligned so OR merges them
    function automatic logic [13:0] pix_addr(input logic [2:0] lx, input logic [2:0] ly,
                                             input logic [1:0] s, input logic [5:0] r,
                                             input logic [5:0] c);
        logic [6:0] y;
        logic [6:0] x;
        y = ({4'b0, ly} << (3'd4 + {1'b0, s})) | {1'b0, r};
        x = ({4'b0, lx} << (3'd4 + {1'b0, s})) | {1'b0, c};
        return {y, x};
    endfunction

    // Raster LCU index used to address the parameter memory
    function automatic logic [5:0] par_index(input logic [2:0] lx, input logic [2:0] ly,
                                             input logic [1:0] s);
        return ({3'b0, ly} << (2'd3 - s)) + {3'b0, lx};
    endfunction

    // LCU geometry, FIFO handshake and read-issue decision
    always_comb begin
        n_m1     = {lcu_size[1], lcu_size[1] | lcu_size[0], 4'hF};
        lcu_max  = 3'd7 >> lcu_size;
        in_en    = (fifo_cnt != 2'd0);
        din      = in_en ? fifo0 : 8'd0;
        pop      = in_en & ~busy;
        push     = rd_valid;
        occ      = fifo_cnt + {1'b0, rd_valid};
        img_rd   = (state == STREAM) && !rd_done &&
                   ((occ < 2'd2) || (pop && (occ == 2'd2)));
        last_rd  = (rd_row == n_m1) && (rd_col == n_m1);
        last_px  = pop && (out_row == n_m1) && (out_col == n_m1);
        last_lcu = (lcu_x == lcu_max) && (lcu_y == lcu_max);
        nx_x     = (lcu_x == lcu_max) ? 3'd0 : lcu_x + 3'd1;
        nx_y     = (lcu_x == lcu_max) ? lcu_y + 3'd1 : lcu_y;
        nr_col   = (rd_col == n_m1) ? 6'd0 : rd_col + 6'd1;
        nr_row   = (rd_col == n_m1) ? rd_row + 6'd1 : rd_row;
    end

    // Frame FSM, address generator, prefetch FIFO and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            param_ph     <= 1'b0;
            rd_row       <= 6'd0;
            rd_col       <= 6'd0;
            rd_done      <= 1'b0;
            rd_valid     <= 1'b0;
            out_row      <= 6'd0;
            out_col      <= 6'd0;
            fifo0        <= 8'd0;
            fifo1        <= 8'd0;
            fifo_cnt     <= 2'd0;
            busy_seen    <= 1'b0;
            img_addr     <= 14'd0;
            par_addr     <= 6'd0;
            ipf_type     <= 2'd0;
            ipf_band_pos <= 5'd0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= 16'd0;
            lcu_x        <= 3'd0;
            lcu_y        <= 3'd0;
            lcu_size     <= 2'd0;
            active       <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= img_rd;

            // Pop shifts the head; a push lands in the first free slot after the pop
            if (push && !pop) begin
                if (fifo_cnt == 2'd0) fifo0 <= img_data;
                else                  fifo1 <= img_data;
                fifo_cnt <= fifo_cnt + 2'd1;
            end else if (!push && pop) begin
                fifo0    <= fifo1;
                fifo_cnt <= fifo_cnt - 2'd1;
            end else if (push && pop) begin
                if (fifo_cnt == 2'd1) begin
                    fifo0 <= img_data;
                end else begin
                    fifo0 <= fifo1;
                    fifo1 <= img_data;
                end
            end

            if (img_rd) begin
                rd_col  <= nr_col;
                rd_row  <= nr_row;
                rd_done <= last_rd;
                if (!last_rd) img_addr <= pix_addr(lcu_x, lcu_y, lcu_size, nr_row, nr_col);
            end

            if (pop) begin
                out_col <= (out_col == n_m1) ? 6'd0 : out_col + 6'd1;
                if (out_col == n_m1) out_row <= out_row + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        lcu_size <= (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
                        lcu_x    <= 3'd0;
                        lcu_y    <= 3'd0;
                        par_addr <= 6'd0;
                        active   <= 1'b1;
                        param_ph <= 1'b0;
                        state    <= PARAM;
                    end
                end
                PARAM: begin
                    if (!param_ph) begin
                        param_ph <= 1'b1;
                    end else begin
                        param_ph     <= 1'b0;
                        ipf_type     <= par_data[23:22];
                        ipf_band_pos <= par_data[21:17];
                        ipf_wo_class <= par_data[16];
                        ipf_offset   <= par_data[15:0];
                        rd_row       <= 6'd0;
                        rd_col       <= 6'd0;
                        rd_done      <= 1'b0;
                        out_row      <= 6'd0;
                        out_col      <= 6'd0;
                        img_addr     <= pix_addr(lcu_x, lcu_y, lcu_size, 6'd0, 6'd0);
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_px) begin
                        if (last_lcu) begin
                            busy_seen <= 1'b0;
                            state     <= WAIT_LAST;
                        end else begin
                            lcu_x    <= nx_x;
                            lcu_y    <= nx_y;
                            par_addr <= par_index(nx_x, nx_y, lcu_size);
                            state    <= PARAM;
                        end
                    end
                end
                WAIT_LAST: begin
                    if (busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen) begin
                        done   <= 1'b1;
                        active <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    img_addr     <= 14'd0;
                    par_addr     <= 6'd0;
                    ipf_type     <= 2'd0;
                    ipf_band_pos <= 5'd0;
                    ipf_wo_class <= 1'b0;
                    ipf_offset   <= 16'd0;
                    lcu_x        <= 3'd0;
                    lcu_y        <= 3'd0;
                    lcu_size     <= 2'd0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IPF_FEEDER_STALL_CNT_EN
    // Saturating count of cycles where a pixel is offered but the IPF is busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cnt <= 16'd0;
        end else if (in_en && busy && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ipf_lcu_feeder.md
# ipf_lcu_feeder

Frame-level pixel source for the in-loop post filter (IPF). Walks a 128x128 8-bit image stored in an external synchronous image memory LCU by LCU in raster order. For each LCU it fetches the filter parameters, then streams pixels row-major to the IPF's `in_en`/`din` input, stalling whenever the IPF asserts `busy`. It is the transmitting end of the IPF pixel-input interface and replaces the testbench-driven feed in the integrated design.

## Interface
- No parameters. Image is fixed at 128x128; LCU edge is N = 16<<lcu_size.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame; ignored while active=1
- cfg_lcu_size  in  2  sampled on accepted start; 0/1/2 = 16/32/64; 3 treated as 2
- img_rd  out  1  image memory read strobe
- img_addr  out  14  image address = row*128 + col
- img_data  in  8  valid exactly one cycle after img_rd
- par_addr  out  6  LCU index = lcu_y*(8>>lcu_size) + lcu_x
- par_data  in  24  {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}; valid one cycle after par_addr changes
- busy  in  1  from IPF
- in_en  out  1  pixel valid to IPF
- din  out  8  pixel to IPF
- ipf_type / ipf_band_pos / ipf_wo_class / ipf_offset  out  2/5/1/16  current LCU parameters
- lcu_x, lcu_y  out  3 each  current LCU coordinates
- lcu_size  out  2  latched frame LCU size
- active  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, PARAM, STREAM, WAIT_LAST, DONE.
- IDLE: all outputs hold reset values. start=1 latches lcu_size, clears lcu_x/lcu_y, sets active, goes to PARAM.
- PARAM: 2 cycles. Cycle 1 drives par_addr. Cycle 2 registers par_data into the ipf_* outputs. Then go to STREAM with row=col=0.
- ipf_* and lcu_x/lcu_y are constant for the whole STREAM of an LCU.
- STREAM: address generator issues reads for pixel (row,col) of the LCU. Address = ((lcu_y*N)+row)*128 + (lcu_x*N)+col. Col increments first; col wraps at N-1, then row increments.
- Read data is pushed into a 2-entry prefetch FIFO. in_en = FIFO non-empty; din = FIFO head.
- A pixel is accepted at an edge where in_en=1 and busy=0; that pops the FIFO.
- img_rd is issued only when (FIFO entries + reads in flight − pop this cycle) < 2. This sustains 1 pixel/cycle when busy=0, and the FIFO never overflows.
- No reads are issued past pixel (N-1,N-1) of the current LCU.
- When pixel (N-1,N-1) is accepted:
  - If the LCU is not the last, advance lcu_x (wraps at (8>>lcu_size)-1, then lcu_y increments) and go to PARAM.
  - If lcu_x = lcu_y = (8>>lcu_size)-1, go to WAIT_LAST.
- WAIT_LAST: wait until busy has been seen high and then low, then go to DONE.
- DONE: done=1 for one cycle, active=0, return to IDLE.

## Timing
- Reset values: in_en=0, din=0, img_rd=0, img_addr=0, par_addr=0, ipf_*=0, lcu_x=lcu_y=0, lcu_size=0, active=0, done=0; state IDLE, FIFO empty.
- Reset mid-frame aborts immediately: FIFO flushed, no done pulse, any in-flight read data discarded.
- start to first img_rd: 3 cycles (accept edge + 2 PARAM cycles). First in_en follows 2 cycles later.
- busy rises the cycle after the IPF accepts the last pixel of a row. While busy=1, in_en may stay high with din held; the head is not popped.
- Data arriving from a read issued before a stall is absorbed by the FIFO (2 entries cover the 1-cycle read latency).
- Between LCUs: in_en=0 for at least 3 cycles while the PARAM fetch runs.
- If busy=1 and a FIFO push happen in the same cycle, the push still completes.

## Configuration
- IPF_FEEDER_STALL_CNT_EN defined: adds output stall_cnt [15:0].
  - Counts cycles with in_en=1 and busy=1.
  - Cleared on accepted start; saturates at 16'hFFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- lcu_size=0, busy tied 0, image = addr[7:0] pattern -> 16384 accepted pixels. LCU (1,0) first din = 16; par_addr runs 0..63; one done pulse.
- lcu_size=2, IPF model holds busy high 70 cycles after each row once row≥2 -> no pixel lost or duplicated; din order matches row-major per LCU; stall_cnt equals total stalled in_en cycles.
- busy toggling randomly every cycle, lcu_size=1 -> accepted stream identical to the busy=0 run; FIFO never exceeds 2 entries.
- par_data differs per LCU (type=1, band_pos=lcu index[4:0]) -> ipf_* changes only between LCUs and is stable across every in_en of an LCU.
- reset asserted mid-STREAM of LCU (2,1) -> all outputs return to reset values next edge; a new start produces a full correct frame.
- cfg_lcu_size=3 -> behaves exactly as 2 (4 LCUs, N=64); start pulsed while active -> ignored.
